// File: rtl/gpr_wport_arbiter.sv
// gpr_wport_arbiter
//
// Shares the single GPR write port between the pipeline write-back stage (WB)
// and the multi-cycle mul/div unit (MD). WB normally wins. MD results wait in
// a small FIFO and drain in idle WB slots. A starvation guard raises wb_stall
// for one cycle when the FIFO head has been denied for MAX_WAIT cycles. The
// pending-destination lookups let decode stall on RAW/WAW hazards against
// buffered MD results.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wb_we, wb_addr, wb_data     WB write request (no backpressure)
//   md_valid, md_ready          MD result handshake
//   md_addr, md_data            MD result destination / value
//   rs/rt/rd_addr               decode lookup addresses
//   rs/rt/rd_pending            lookup hits a buffered, not-yet-written MD result
//   wb_stall                    registered; WB must not write this cycle
//   gpr_we, gpr_waddr, gpr_wdata  GPR write port (combinational)
//   fifo_count                  number of buffered MD results
//   proto_err                   sticky; WB wrote while wb_stall was high
module gpr_wport_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_we,
    input  logic [4:0]                 wb_addr,
    input  logic [31:0]                wb_data,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [4:0]                 md_addr,
    input  logic [31:0]                md_data,
    input  logic [4:0]                 rs_addr,
    input  logic [4:0]                 rt_addr,
    input  logic [4:0]                 rd_addr,
    output logic                       rs_pending,
    output logic                       rt_pending,
    output logic                       rd_pending,
    output logic                       wb_stall,
    output logic                       gpr_we,
    output logic [4:0]                 gpr_waddr,
    output logic [31:0]                gpr_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // The counter reaches MAX_WAIT in the forced-bubble cycle before clearing.
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          wb_stall_reg, wb_stall_next;
    logic          proto_err_reg, proto_err_next;

    logic          fifo_empty;
    logic          head_grant;
    logic          enq;

    assign fifo_empty = (count_reg == '0);
    assign md_ready   = (count_reg != CW'(DEPTH));
    // During a forced bubble the head wins even if WB (illegally) writes.
    assign head_grant = !fifo_empty && (wb_stall_reg || !wb_we);
    // Writes to r0 are handshaken but never buffered.
    assign enq        = md_valid && md_ready && (md_addr != 5'd0);

    // Write-port mux; held quiet while reset is asserted.
    always_comb begin
        gpr_we    = 1'b0;
        gpr_waddr = 5'd0;
        gpr_wdata = 32'd0;
        if (!rst) begin
            if (head_grant) begin
                gpr_waddr = addr_mem[rd_ptr_reg];
                gpr_wdata = data_mem[rd_ptr_reg];
                gpr_we    = (addr_mem[rd_ptr_reg] != 5'd0);
            end else if (wb_we) begin
                gpr_waddr = wb_addr;
                gpr_wdata = wb_data;
                gpr_we    = (wb_addr != 5'd0);
            end
        end
    end

    // Per-entry hazard match. An entry is live when its offset from the head
    // is below the count; the head is excluded in the cycle it is written
    // because the GPR bypass forwards it then.
    logic [DEPTH-1:0] ent_live;
    logic [DEPTH-1:0] rs_hit, rt_hit, rd_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [AW-1:0] off;
            assign off          = AW'(gi) - rd_ptr_reg;
            assign ent_live[gi] = ({1'b0, off} < count_reg) &&
                                  !(head_grant && (rd_ptr_reg == AW'(gi)));
            assign rs_hit[gi]   = ent_live[gi] && (addr_mem[gi] == rs_addr);
            assign rt_hit[gi]   = ent_live[gi] && (addr_mem[gi] == rt_addr);
            assign rd_hit[gi]   = ent_live[gi] && (addr_mem[gi] == rd_addr);
        end
    endgenerate

    assign rs_pending = (rs_addr != 5'd0) && (|rs_hit);
    assign rt_pending = (rt_addr != 5'd0) && (|rt_hit);
    assign rd_pending = (rd_addr != 5'd0) && (|rd_hit);

    assign wb_stall   = wb_stall_reg;
    assign proto_err  = proto_err_reg;
    assign fifo_count = count_reg;

    always_comb begin
        rd_ptr_next    = head_grant ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        wr_ptr_next    = enq ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        count_next     = count_reg;
        case ({enq, head_grant})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        wait_cnt_next  = (fifo_empty || head_grant) ? '0 : wait_cnt_reg + WW'(1);
        wb_stall_next  = !fifo_empty && !head_grant &&
                         (wait_cnt_reg == WW'(MAX_WAIT - 1));
        proto_err_next = proto_err_reg || (wb_we && wb_stall_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            wait_cnt_reg  <= '0;
            wb_stall_reg  <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            wait_cnt_reg  <= wait_cnt_next;
            wb_stall_reg  <= wb_stall_next;
            proto_err_reg <= proto_err_next;
        end
    end

    // Storage needs no reset: validity is carried by the count and pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_reg] <= md_addr;
            data_mem[wr_ptr_reg] <= md_data;
        end
    end

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
module tb_gpr_wport_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        rs_pending, rt_pending, rd_pending;
    logic        wb_stall;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [2:0]  fifo_count;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    gpr_wport_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_pending(rs_pending), .rt_pending(rt_pending), .rd_pending(rd_pending),
        .wb_stall(wb_stall), .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .fifo_count(fifo_count), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  rs, rt, rd;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_rsp, e_rtp, e_rdp;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input int we, input int wa, input logic [31:0] wd,
                                input int mv, input int ma, input logic [31:0] md,
                                input int rs, input int rt, input int rd,
                                input int e_we, input int e_wa, input logic [31:0] e_wd,
                                input int e_rdy, input int e_cnt,
                                input int e_rsp, input int e_rtp, input int e_rdp);
        vec_t v;
        v.we = 1'(we); v.wa = 5'(wa); v.wd = wd;
        v.mv = 1'(mv); v.ma = 5'(ma); v.md = md;
        v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
        v.e_we = 1'(e_we); v.e_wa = 5'(e_wa); v.e_wd = e_wd;
        v.e_rdy = 1'(e_rdy); v.e_cnt = 3'(e_cnt);
        v.e_rsp = 1'(e_rsp); v.e_rtp = 1'(e_rtp); v.e_rdp = 1'(e_rdp);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        md_valid = 1'b0; md_addr = 5'd0; md_data = 32'd0;
        rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One cycle: drive after the edge, compare mid-cycle before the next edge.
    task automatic apply_vec(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        wb_we = v.we; wb_addr = v.wa; wb_data = v.wd;
        md_valid = v.mv; md_addr = v.ma; md_data = v.md;
        rs_addr = v.rs; rt_addr = v.rt; rd_addr = v.rd;
        #3;
        $display("vec %0d: gpr_we=%0b waddr=%0d wdata=%h cnt=%0d rdy=%0b pend=%0b%0b%0b",
                 idx, gpr_we, gpr_waddr, gpr_wdata, fifo_count, md_ready,
                 rs_pending, rt_pending, rd_pending);
        chk($sformatf("v%0d_gpr_we", idx), 32'(gpr_we), 32'(v.e_we));
        if (v.e_we) begin
            chk($sformatf("v%0d_waddr", idx), 32'(gpr_waddr), 32'(v.e_wa));
            chk($sformatf("v%0d_wdata", idx), gpr_wdata, v.e_wd);
        end
        chk($sformatf("v%0d_ready", idx), 32'(md_ready), 32'(v.e_rdy));
        chk($sformatf("v%0d_count", idx), 32'(fifo_count), 32'(v.e_cnt));
        chk($sformatf("v%0d_rs_pend", idx), 32'(rs_pending), 32'(v.e_rsp));
        chk($sformatf("v%0d_rt_pend", idx), 32'(rt_pending), 32'(v.e_rtp));
        chk($sformatf("v%0d_rd_pend", idx), 32'(rd_pending), 32'(v.e_rdp));
        chk($sformatf("v%0d_stall", idx), 32'(wb_stall), 32'd0);
        chk($sformatf("v%0d_perr", idx), 32'(proto_err), 32'd0);
    endtask

    // Starvation: WB busy, one MD push; bubble arrives 9 cycles after the push.
    task automatic starve_seq(input logic keep_we, input string tag);
        do_reset();
        @(posedge clk); #1;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h100;
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h900D;
        #3;
        chk({tag, "_push_wb_addr"}, 32'(gpr_waddr), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            md_valid = 1'b0; wb_data = 32'h100 + 32'(k);
            #3;
            $display("%s cyc %0d: gpr_we=%0b waddr=%0d stall=%0b cnt=%0d",
                     tag, k, gpr_we, gpr_waddr, wb_stall, fifo_count);
            chk($sformatf("%s_c%0d_waddr", tag, k), 32'(gpr_waddr), 32'd1);
            chk($sformatf("%s_c%0d_stall", tag, k), 32'(wb_stall), 32'd0);
            chk($sformatf("%s_c%0d_count", tag, k), 32'(fifo_count), 32'd1);
        end
        @(posedge clk); #1;
        wb_we = keep_we;
        #3;
        $display("%s cyc 9: gpr_we=%0b waddr=%0d stall=%0b", tag, gpr_we, gpr_waddr, wb_stall);
        chk({tag, "_c9_stall"}, 32'(wb_stall), 32'd1);
        chk({tag, "_c9_gpr_we"}, 32'(gpr_we), 32'd1);
        chk({tag, "_c9_waddr"}, 32'(gpr_waddr), 32'd9);
        chk({tag, "_c9_wdata"}, gpr_wdata, 32'h900D);
        for (int k = 10; k <= 11; k++) begin
            @(posedge clk); #1;
            wb_we = 1'b1;
            #3;
            $display("%s cyc %0d: stall=%0b cnt=%0d perr=%0b", tag, k, wb_stall, fifo_count, proto_err);
            chk($sformatf("%s_c%0d_stall", tag, k), 32'(wb_stall), 32'd0);
            chk($sformatf("%s_c%0d_count", tag, k), 32'(fifo_count), 32'd0);
            chk($sformatf("%s_c%0d_perr", tag, k), 32'(proto_err), 32'(keep_we));
            chk($sformatf("%s_c%0d_waddr", tag, k), 32'(gpr_waddr), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        // Reset state, with a WB request present to show the port is held quiet.
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1;
        #2;
        $display("reset: cnt=%0d stall=%0b perr=%0b gpr_we=%0b", fifo_count, wb_stall, proto_err, gpr_we);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_stall", 32'(wb_stall), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        chk("rst_gpr_we", 32'(gpr_we), 32'd0);
        chk("rst_ready", 32'(md_ready), 32'd1);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //            we wa wd            mv ma md          rs rt rd  ewe ewa ewd          rdy cnt rsp rtp rdp
        vecs[0] = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,      0, 0, 0,  1,  5, 32'hDEADBEEF, 1,  0,  0,  0,  0);
        vecs[1] = mk(0, 0, 32'h0,        1, 7, 32'h1234,   7, 0, 0,  0,  0, 32'h0,        1,  0,  0,  0,  0);
        vecs[2] = mk(0, 0, 32'h0,        0, 0, 32'h0,      7, 0, 0,  1,  7, 32'h1234,     1,  1,  0,  0,  0);
        vecs[3] = mk(0, 0, 32'h0,        0, 0, 32'h0,      7, 0, 0,  0,  0, 32'h0,        1,  0,  0,  0,  0);
        vecs[4] = mk(0, 0, 32'h0,        1, 7, 32'h5678,   7, 0, 0,  0,  0, 32'h0,        1,  0,  0,  0,  0);
        vecs[5] = mk(1, 3, 32'h33,       0, 0, 32'h0,      7, 7, 2,  1,  3, 32'h33,       1,  1,  1,  1,  0);
        vecs[6] = mk(0, 0, 32'h0,        0, 0, 32'h0,      7, 7, 0,  1,  7, 32'h5678,     1,  1,  0,  0,  0);
        vecs[7] = mk(0, 0, 32'h0,        1, 0, 32'h99,     0, 0, 0,  0,  0, 32'h0,        1,  0,  0,  0,  0);
        vecs[8] = mk(1, 0, 32'hAA,       0, 0, 32'h0,      0, 0, 0,  0,  0, 32'h0,        1,  0,  0,  0,  0);
        vecs[9] = mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0,  0,  0, 32'h0,        1,  0,  0,  0,  0);

        for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

        starve_seq(1'b0, "starve_drop");
        starve_seq(1'b1, "starve_keep");

        // Full FIFO: four pushes behind a busy WB, fifth held, then drain in order.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
            md_valid = 1'b1; md_addr = 5'(11 + k); md_data = 32'hA0 + 32'(k);
            rs_addr = 5'd14; rt_addr = 5'd15; rd_addr = 5'd11;
            #3;
            $display("fill %0d: cnt=%0d rdy=%0b", k, fifo_count, md_ready);
            chk($sformatf("fill%0d_count", k), 32'(fifo_count), 32'(k));
            chk($sformatf("fill%0d_ready", k), 32'(md_ready), 32'(k < 4));
        end
        chk("full_rs_pend", 32'(rs_pending), 32'd1);
        chk("full_rt_pend", 32'(rt_pending), 32'd0);
        chk("full_rd_pend", 32'(rd_pending), 32'd1);
        begin
            int exp_cnt [5] = '{4, 3, 3, 2, 1};
            int exp_rdy [5] = '{0, 1, 1, 1, 1};
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                wb_we = 1'b0;
                if (k >= 2) md_valid = 1'b0;
                #3;
                $display("drain %0d: gpr_we=%0b waddr=%0d wdata=%h cnt=%0d rdy=%0b",
                         k, gpr_we, gpr_waddr, gpr_wdata, fifo_count, md_ready);
                chk($sformatf("drain%0d_gpr_we", k), 32'(gpr_we), 32'd1);
                chk($sformatf("drain%0d_waddr", k), 32'(gpr_waddr), 32'(11 + k));
                chk($sformatf("drain%0d_wdata", k), gpr_wdata, 32'hA0 + 32'(k));
                chk($sformatf("drain%0d_count", k), 32'(fifo_count), 32'(exp_cnt[k]));
                chk($sformatf("drain%0d_ready", k), 32'(md_ready), 32'(exp_rdy[k]));
            end
        end
        @(posedge clk); #4;
        chk("drained_count", 32'(fifo_count), 32'd0);
        chk("drained_gpr_we", 32'(gpr_we), 32'd0);

        // Asynchronous reset with three entries buffered.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
            md_valid = 1'b1; md_addr = 5'(20 + k); md_data = 32'hC0 + 32'(k);
            rs_addr = 5'd21;
        end
        @(posedge clk); #1;
        md_valid = 1'b0;
        #3;
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_rs_pend", 32'(rs_pending), 32'd1);
        #1 rst = 1'b1;
        #1;
        $display("async rst: cnt=%0d pend=%0b stall=%0b gpr_we=%0b", fifo_count, rs_pending, wb_stall, gpr_we);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_rs_pend", 32'(rs_pending), 32'd0);
        chk("arst_stall", 32'(wb_stall), 32'd0);
        chk("arst_gpr_we", 32'(gpr_we), 32'd0);
        @(posedge clk); #1;
        wb_we = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #3;
            $display("post rst %0d: gpr_we=%0b cnt=%0d", k, gpr_we, fifo_count);
            chk($sformatf("post_rst%0d_gpr_we", k), 32'(gpr_we), 32'd0);
            chk($sformatf("post_rst%0d_count", k), 32'(fifo_count), 32'd0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_wport_arbiter.md
Name: gpr_wport_arbiter

Overview:
Shares the single GPR write port between the pipeline write-back stage (WB) and the multi-cycle mul/div unit (MD). WB has priority. MD results are buffered in a small FIFO and drained in idle WB slots. A starvation guard forces a one-cycle WB bubble when an MD result has waited too long. Pending-destination lookups feed the decode hazard logic, so RAW and WAW hazards on buffered MD results stall issue.

Parameters:
DEPTH, 4, MD result FIFO entries (power of 2, >=2)
MAX_WAIT, 8, cycles a FIFO head may be denied before a forced WB bubble (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wb_we  in  1  WB write request (no backpressure)
wb_addr  in  5  WB destination
wb_data  in  32  WB data
md_valid  in  1  MD result valid
md_ready  out  1  FIFO can accept
md_addr  in  5  MD destination
md_data  in  32  MD data
rs_addr, rt_addr, rd_addr  in  5 each  decode lookup addresses
rs_pending, rt_pending, rd_pending  out  1 each  address matches a buffered MD result
wb_stall  out  1  registered; WB must present wb_we=0 this cycle
gpr_we  out  1  to GPR regWr
gpr_waddr  out  5  to GPR WriteReg
gpr_wdata  out  32  to GPR busW
fifo_count  out  clog2(DEPTH)+1  valid entries
proto_err  out  1  sticky; wb_we seen while wb_stall=1

Behaviour:
- Reset (async): FIFO flushed, fifo_count=0, wait_cnt=0, wb_stall=0, proto_err=0. The gpr_* outputs are combinational and read 0 while rst=1. Reset mid-operation discards buffered results without writing them.
- Grant, combinational, per cycle:
  - If wb_stall=1 and FIFO non-empty: MD head granted.
  - Else if wb_we=1: WB granted.
  - Else if FIFO non-empty: MD head granted.
  - Else: idle, gpr_we=0.
- gpr_we/gpr_waddr/gpr_wdata come from the granted source in the same cycle. WB has zero latency.
- gpr_we is forced to 0 when the granted address is 0.
- Head dequeues at the clock edge of its grant.
- Enqueue: on md_valid & md_ready at the edge. md_ready = (fifo_count != DEPTH), using the registered count, so no enqueue while full even if a dequeue occurs the same cycle. An entry enqueued at edge t is grantable from cycle t+1.
- An accepted md_addr=0 is handshaken but discarded (not enqueued).
- Pending: X_pending=1 iff X_addr!=0 and X_addr matches any valid FIFO entry, excluding the head when it is granted this cycle (the GPR bypass covers that cycle). The MD input port is not included in the match.
- Starvation counter wait_cnt:
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise incremented.
  - When wait_cnt==MAX_WAIT-1 and the head is not granted, wb_stall<=1 for exactly the next cycle, then returns to 0.
- If wb_we=1 while wb_stall=1: MD still granted, WB write lost, proto_err<=1 (sticky until rst).
- Entries retire in FIFO order. Pointers wrap modulo DEPTH.
- Simultaneous enqueue and dequeue with FIFO non-full: count unchanged.

Test Plan:
1. FIFO empty; wb_we=1, wb_addr=5, wb_data=0xDEADBEEF -> same cycle gpr_we=1, gpr_waddr=5, gpr_wdata=0xDEADBEEF; fifo_count=0.
2. WB idle; MD push (7, 0x00001234) at edge t -> cycle t+1: gpr_we=1, gpr_waddr=7, rs_addr=7 gives rs_pending=0. With wb_we=1 held at t+1 instead -> rs_pending=1 until the write is granted.
3. wb_we=1 continuously; MD push at edge t, MAX_WAIT=8 -> no MD grant in cycles t+1..t+8; wb_stall=1 in cycle t+9 only; bench drops wb_we there -> MD written in t+9; proto_err stays 0.
4. Same as 3 but bench keeps wb_we=1 in t+9 -> MD granted, proto_err=1, sticky through later cycles.
5. wb_we=1 held, 5 MD pushes -> after 4: fifo_count=4, md_ready=0, fifth held. Release WB -> drains in order, one per cycle; md_ready=1 once the count is below 4 at an edge.
6. MD push to r0 -> handshake completes, fifo_count stays 0, never gpr_we. WB to r0 -> gpr_we=0.
7. 3 entries buffered, assert rst mid-cycle -> immediately fifo_count=0, pending=0, wb_stall=0; no buffered write appears after reset release.
